// File: rtl/spi_peripheral.sv
// SPI peripheral endpoint: CPOL=1/CPHA=1, MSB first, 8-bit words.
// SCK/SS_N/MOSI are oversampled through SYNC_STAGES flops and acted on SYNC_STAGES+1 clk after a pin change.
// Optional RX FIFO of FIFO_DEPTH entries when SPI_PERIPHERAL_RX_FIFO_EN is defined, otherwise a single holding register.
module spi_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic       busy
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FIFO_DEPTH < 1) begin : g_bad_depth
    $error("FIFO_DEPTH must be at least 1");
  end

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_dly_q, ss_dly_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             tx_shift_q, rx_shift_q, hold_q;
  logic                   hold_full_q, miso_q, overrun_q;

  logic sck_s, ss_s, mosi_s;
  logic sck_rise, sck_fall, sel_start, sel_end, active;
  logic byte_done, tx_load, tx_accept, rx_pop, rx_full, rx_push_ok, rx_drop;
  logic [7:0] rx_byte, tx_load_val;

  // Synchronizers; idle levels on reset so no edge is seen leaving reset with idle pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q  <= '1;
      ss_sync_q   <= '1;
      mosi_sync_q <= '1;
      sck_dly_q   <= 1'b1;
      ss_dly_q    <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_dly_q   <= sck_sync_q[SYNC_STAGES-1];
      ss_dly_q    <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_dly_q;
  assign sck_fall  = ~sck_s & sck_dly_q;
  assign sel_start = ~ss_s & ss_dly_q;
  assign sel_end   = ss_s & ~ss_dly_q;
  assign active    = (state_q == ACTIVE);

  // Deselect wins over a coincident SCK edge: the byte is abandoned.
  assign byte_done   = active & ~sel_end & sck_rise & (bit_cnt_q == 3'd7);
  assign tx_load     = (~active & sel_start) | byte_done;
  assign tx_load_val = hold_full_q ? hold_q : 8'hFF;
  assign tx_accept   = tx_valid & ~hold_full_q;
  assign rx_byte     = {rx_shift_q[6:0], mosi_s};
  assign rx_pop      = rx_ack & rx_valid;
  // A pop in the same cycle frees the slot the push needs.
  assign rx_push_ok  = byte_done & (~rx_full | rx_pop);
  assign rx_drop     = byte_done & rx_full & ~rx_pop;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: selection edges move between IDLE and ACTIVE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_start) state_d = ACTIVE;
      ACTIVE:  if (sel_end)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit counter, TX/RX shifters and MISO bit; SCK edges only matter while ACTIVE.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q  <= 3'd0;
      tx_shift_q <= 8'hFF;
      rx_shift_q <= 8'hFF;
      miso_q     <= 1'b1;
    end else if (!active) begin
      if (sel_start) begin
        bit_cnt_q  <= 3'd0;
        tx_shift_q <= tx_load_val;
        miso_q     <= 1'b1;
      end
    end else if (sel_end) begin
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'hFF;
      miso_q     <= 1'b1;
    end else if (sck_fall) begin
      miso_q     <= tx_shift_q[7];
      tx_shift_q <= {tx_shift_q[6:0], 1'b1};
    end else if (sck_rise) begin
      rx_shift_q <= rx_byte;
      bit_cnt_q  <= bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) tx_shift_q <= tx_load_val;
    end
  end

  // TX holding register: a load drains it, an accept in the same cycle refills it.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else if (tx_accept) begin
      hold_q      <= tx_data;
      hold_full_q <= 1'b1;
    end else if (tx_load) begin
      hold_full_q <= 1'b0;
    end
  end

  // Sticky overrun; a new drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= (overrun_q & ~overrun_clr) | rx_drop;
  end

`ifdef SPI_PERIPHERAL_RX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  assign rx_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign rx_valid = (count_q != '0);
  assign rx_data  = mem_q[rd_ptr_q];

  // RX FIFO: pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (rx_push_ok) begin
        mem_q[wr_ptr_q] <= rx_byte;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (rx_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({rx_push_ok, rx_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
`else
  logic [7:0] rx_hold_q;
  logic       rx_full_q;

  assign rx_full  = rx_full_q;
  assign rx_valid = rx_full_q;
  assign rx_data  = rx_hold_q;

  // Single-entry RX holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_hold_q <= 8'h00;
      rx_full_q <= 1'b0;
    end else if (rx_push_ok) begin
      rx_hold_q <= rx_byte;
      rx_full_q <= 1'b1;
    end else if (rx_pop) begin
      rx_full_q <= 1'b0;
    end
  end
`endif

  assign miso     = active ? miso_q : 1'b1;
  assign miso_oe  = active;
  assign tx_ready = ~hold_full_q;
  assign overrun  = overrun_q;
  assign busy     = ~ss_s;

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

SPI peripheral (slave) endpoint that receives bytes from an external SPI controller and returns bytes on MISO in the same transfer. It is the far-end counterpart of our SPI controller: CPOL=1/CPHA=1 framing (SCK idles high, data driven on falling SCK, sampled on rising SCK), MSB first, 8-bit words. SCK, SS_N and MOSI are asynchronous to `clk` and are oversampled; all outputs and internal state are in the `clk` domain. It sits between the board SPI pins and a byte-wide local bus.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `sck`, `ss_n`, `mosi` (minimum 2).
- `FIFO_DEPTH`, 4: RX FIFO entries, power of two; used only when the FIFO is compiled in.

- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `sck` input 1: SPI clock from the external controller, asynchronous.
- `ss_n` input 1: active-low select, asynchronous.
- `mosi` input 1: serial data in, asynchronous.
- `miso` output 1: serial data out.
- `miso_oe` output 1: MISO output enable, high while selected.
- `tx_data` input 8: next byte to return.
- `tx_valid` input 1: `tx_data` is offered.
- `tx_ready` output 1: holding register empty; byte accepted when `tx_valid && tx_ready`.
- `rx_data` output 8: received byte.
- `rx_valid` output 1: `rx_data` holds an unread byte.
- `rx_ack` input 1: consume `rx_data`; ignored when `rx_valid` low.
- `overrun` output 1: sticky, a received byte was dropped.
- `overrun_clr` input 1: clears `overrun`.
- `busy` output 1: synchronized `ss_n` is low.

## Operation
- Inputs pass through `SYNC_STAGES` flops; edges detected by comparing last synchronizer stage to one extra registered copy. `sck_rise`, `sck_fall`, `sel_start` (ss_n falling), `sel_end` (ss_n rising) are one-cycle pulses.
- States: IDLE, ACTIVE. IDLE -> ACTIVE on `sel_start`: bit counter = 0, TX shifter loaded. ACTIVE -> IDLE on `sel_end`: bit counter cleared, partial RX byte discarded. SCK edges ignored in IDLE.
- TX load (at `sel_start` and after each completed byte): holding register full -> shifter gets it, holding cleared; empty -> shifter gets 8'hFF.
- `sck_fall` in ACTIVE: `miso` <= shifter[7], shifter shifts left by one.
- `sck_rise` in ACTIVE: RX shifter <= {rx_shift[6:0], mosi_sync}; bit counter +1 (3 bits, wraps 7 -> 0). On wrap: byte complete, RX byte pushed, TX load occurs same cycle.
- RX push: storage full -> byte dropped, `overrun` set. Push and `rx_ack` pop in same cycle when full: pop first, push succeeds, no overrun.
- `overrun_clr` and new overrun in same cycle: `overrun` stays set.
- `tx_valid && tx_ready` and TX load in same cycle: load takes the old holding contents (empty -> 8'hFF); new byte written into holding.
- `miso_oe` = ACTIVE; `miso` = 1 when not ACTIVE.

## Timing
- Reset values: `miso`=1, `miso_oe`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=8'h00, `overrun`=0, `busy`=0; state IDLE, counter 0, shifters 8'hFF, storage empty.
- Pin-to-detect latency: `SYNC_STAGES`+1 clk.
- External SCK high and low phases must each be ≥ `SYNC_STAGES`+2 clk; ss_n setup to first SCK fall ≥ `SYNC_STAGES`+3 clk.
- `miso` updates 1 clk after `sck_fall` pulse.
- `rx_valid` rises 1 clk after the 8th `sck_rise` pulse; `rx_ack` removes the byte on the next edge.
- `tx_ready` falls the clk after acceptance, rises the clk after TX load.
- `reset` mid-transfer: returns to reset values next edge; transfer abandoned, resumes only after a fresh `sel_start`.

## Configuration
- `SPI_PERIPHERAL_RX_FIFO_EN` defined: RX storage is a `FIFO_DEPTH`-entry FIFO; `rx_valid` = not empty, `rx_data` = head entry, `rx_ack` pops.
- Undefined: RX storage is a single holding register (depth 1); `FIFO_DEPTH` ignored. Full/overrun rules identical with depth 1.

## Test plan
- Reset, then select; controller sends 8'hA5 with `tx_data`=8'h3C preloaded -> `rx_data`=8'hA5, `rx_valid` high; controller captures 8'h3C on MISO.
- Three back-to-back bytes 8'h01,8'h02,8'h03 in one select, no TX preload -> MISO returns 8'hFF each; received in order (FIFO) or only 8'h01 kept with `overrun`=1 (no FIFO, no `rx_ack`).
- `FIFO_DEPTH`+1 bytes with no `rx_ack` -> first `FIFO_DEPTH` kept, last dropped, `overrun`=1; `overrun_clr` -> 0.
- ss_n deasserted after 5 SCK cycles, then new 8'h5A transfer -> no byte from partial transfer, next `rx_data`=8'h5A.
- `reset` pulsed after 4 bits of a transfer -> all outputs at reset values next clk; following full transfer of 8'hC3 received correctly.
